// File: rtl/psum_collector_pkg.sv
// Shared sizing constants for the systolic array, core and psum collector.
package psum_collector_pkg;

  localparam int COL     = 8;
  localparam int PSUM_BW = 16;
  localparam int DEPTH   = 8;

  function automatic int ptr_w(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

endpackage

// File: rtl/psum_fifo_lane.sv
// Single-lane psum FIFO: power-of-two depth, occupancy counter, sticky overflow.
module psum_fifo_lane
  import psum_collector_pkg::*;
#(
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [psum_bw-1:0] din,
  output logic [psum_bw-1:0] dout,
  output logic               full,
  output logic               empty,
  output logic               overflow
);

  localparam int AW = ptr_w(depth);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(depth);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [psum_bw-1:0] mem [depth];
  logic [AW-1:0]      wptr;
  logic [AW-1:0]      rptr;
  logic [AW:0]        count;
  logic               do_push;
  logic               do_pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign dout  = mem[rptr];

  // A full lane can still take a write when its head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (push && !do_push) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/psum_collector.sv
// Collects skewed south-edge psums into per-lane FIFOs and pops whole rows.
module psum_collector
  import psum_collector_pkg::*;
#(
  parameter int col     = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   out_valid,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   overflow
);

  logic [col-1:0]         lane_full;
  logic [col-1:0]         lane_empty;
  logic [col-1:0]         lane_ovf;
  logic [psum_bw*col-1:0] row_p0;
  logic                   pop_p0;
  logic [psum_bw*col-1:0] row_p1;
  logic                   vld_p1;

  // Status flags come only from lane registers, never from wr/rd.
  assign o_valid  = ~|lane_empty;
  assign o_full   = |lane_full;
  assign overflow = |lane_ovf;
  assign pop_p0   = rd & o_valid;

  for (genvar c = 0; c < col; c++) begin : g_lane
    psum_fifo_lane #(
      .psum_bw (psum_bw),
      .depth   (depth)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .push     (wr[c]),
      .pop      (pop_p0),
      .din      (in[c*psum_bw +: psum_bw]),
      .dout     (row_p0[c*psum_bw +: psum_bw]),
      .full     (lane_full[c]),
      .empty    (lane_empty[c]),
      .overflow (lane_ovf[c])
    );
  end

  // p0 -> p1: register the popped row; hold it between pops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= pop_p0;
      if (pop_p0) row_p1 <= row_p0;
    end
  end

  assign out       = row_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_psum_collector.sv
// Directed bench for psum_collector: skew, full/overflow, simultaneous, wrap, reset.
module tb_psum_collector;

  logic         clk;
  logic         reset;
  logic [127:0] in_bus;
  logic [7:0]   wr;
  logic         rd;
  logic [127:0] out_bus;
  logic         out_valid;
  logic         o_valid;
  logic         o_full;
  logic         overflow;

  int n_tests;
  int n_fail;

  psum_collector #(.col(8), .psum_bw(16), .depth(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in_bus),
    .wr        (wr),
    .rd        (rd),
    .out       (out_bus),
    .out_valid (out_valid),
    .o_valid   (o_valid),
    .o_full    (o_full),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] rep(input logic [15:0] v);
    return {8{v}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a step, so the pulse sits well away from any edge.
  task automatic do_reset();
    wr = '0; rd = 1'b0; in_bus = '0;
    reset = 1'b0;
    #3;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; wr = '0; rd = 1'b0; in_bus = '0;
    #12;
    n_tests++; if (out_bus !== '0) begin n_fail++; $display("FAIL reset_out: got %h expected 0", out_bus); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid: got %b expected 0", o_valid); end
    n_tests++; if (o_full !== 1'b0) begin n_fail++; $display("FAIL reset_o_full: got %b expected 0", o_full); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_skew();
    logic [127:0] exp_row;
    exp_row = 128'h0107_0106_0105_0104_0103_0102_0101_0100;
    for (int c = 0; c < 8; c++) begin
      wr = 8'(1 << c);
      in_bus = '0;
      in_bus[c*16 +: 16] = 16'h0100 + 16'(c);
      if (c == 7) begin
        n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL skew_o_valid_early: got %b expected 0", o_valid); end
      end
      step();
    end
    wr = '0;
    n_tests++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL skew_o_valid: got %b expected 1", o_valid); end
    rd = 1'b1;
    step();
    rd = 1'b0;
    n_tests++; if (out_bus !== exp_row) begin n_fail++; $display("FAIL skew_row: got %h expected %h", out_bus, exp_row); end
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL skew_out_valid: got %b expected 1", out_valid); end
    step();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL skew_out_valid_drop: got %b expected 0", out_valid); end
    n_tests++; if (out_bus !== exp_row) begin n_fail++; $display("FAIL skew_row_hold: got %h expected %h", out_bus, exp_row); end
    n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL skew_drained: got %b expected 0", o_valid); end
  endtask

  task automatic test_full_overflow();
    do_reset();
    step();
    for (int r = 0; r < 8; r++) begin
      if (r == 7) begin
        n_tests++; if (o_full !== 1'b0) begin n_fail++; $display("FAIL full_early: got %b expected 0", o_full); end
      end
      wr = 8'hFF; in_bus = rep(16'h1000 + 16'(r));
      step();
    end
    wr = '0;
    n_tests++; if (o_full !== 1'b1) begin n_fail++; $display("FAIL full_flag: got %b expected 1", o_full); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_no_ovf: got %b expected 0", overflow); end
    wr = 8'hFF; in_bus = rep(16'hDEAD);
    step();
    wr = '0;
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    n_tests++; if (o_full !== 1'b1) begin n_fail++; $display("FAIL ovf_still_full: got %b expected 1", o_full); end
    rd = 1'b1;
    for (int r = 0; r < 8; r++) begin
      step();
      n_tests++;
      if (out_bus !== rep(16'h1000 + 16'(r)) || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL full_pop%0d: got %h/%b expected %h/1", r, out_bus, out_valid, rep(16'h1000 + 16'(r)));
      end
    end
    rd = 1'b0;
    n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL full_drained: got %b expected 0", o_valid); end
    step();
    n_tests++; if (out_valid !== 1'b0 || out_bus !== rep(16'h1007)) begin n_fail++; $display("FAIL full_no_dead: got %h/%b expected %h/0", out_bus, out_valid, rep(16'h1007)); end
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    step();
    for (int r = 0; r < 8; r++) begin
      wr = 8'hFF; in_bus = rep(16'h2000 + 16'(r));
      step();
    end
    wr = 8'hFF; in_bus = rep(16'h2FFF); rd = 1'b1;
    step();
    wr = '0;
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL simul_ovf: got %b expected 0", overflow); end
    n_tests++; if (o_full !== 1'b1) begin n_fail++; $display("FAIL simul_full: got %b expected 1", o_full); end
    n_tests++; if (out_bus !== rep(16'h2000) || out_valid !== 1'b1) begin n_fail++; $display("FAIL simul_head: got %h/%b expected %h/1", out_bus, out_valid, rep(16'h2000)); end
    for (int r = 1; r < 9; r++) begin
      logic [15:0] ev;
      ev = (r == 8) ? 16'h2FFF : 16'h2000 + 16'(r);
      step();
      n_tests++;
      if (out_bus !== rep(ev) || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL simul_pop%0d: got %h/%b expected %h/1", r, out_bus, out_valid, rep(ev));
      end
    end
    rd = 1'b0;
    n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL simul_drained: got %b expected 0", o_valid); end
  endtask

  task automatic test_empty_read();
    do_reset();
    step();
    rd = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      n_tests++;
      if (out_valid !== 1'b0 || out_bus !== '0 || o_valid !== 1'b0) begin
        n_fail++; $display("FAIL empty_rd%0d: got %b/%h/%b expected 0/0/0", k, out_valid, out_bus, o_valid);
      end
    end
    wr = 8'hFF; in_bus = rep(16'h0A0A);
    step();
    wr = '0;
    n_tests++; if (out_valid !== 1'b0 || o_valid !== 1'b1) begin n_fail++; $display("FAIL empty_same_cycle: got %b/%b expected 0/1", out_valid, o_valid); end
    step();
    rd = 1'b0;
    n_tests++; if (out_bus !== rep(16'h0A0A) || out_valid !== 1'b1) begin n_fail++; $display("FAIL empty_next_pop: got %h/%b expected %h/1", out_bus, out_valid, rep(16'h0A0A)); end
  endtask

  task automatic test_wrap();
    do_reset();
    step();
    for (int i = 0; i <= 20; i++) begin
      wr = (i < 20) ? 8'hFF : 8'h00;
      in_bus = rep(16'(i));
      rd = (i > 0);
      step();
      if (i > 0) begin
        n_tests++;
        if (out_bus !== rep(16'(i - 1)) || out_valid !== 1'b1) begin
          n_fail++; $display("FAIL wrap%0d: got %h/%b expected %h/1", i - 1, out_bus, out_valid, rep(16'(i - 1)));
        end
      end
    end
    wr = '0; rd = 1'b0;
    n_tests++; if (o_valid !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL wrap_end: got %b/%b expected 0/0", o_valid, overflow); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    step();
    for (int r = 0; r < 3; r++) begin
      wr = 8'hFF; in_bus = rep(16'h3000 + 16'(r));
      step();
    end
    wr = '0; rd = 1'b1;
    step();
    rd = 1'b0;
    n_tests++; if (out_bus !== rep(16'h3000) || out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got %h/%b expected %h/1", out_bus, out_valid, rep(16'h3000)); end
    #2;
    reset = 1'b0;
    #1;
    n_tests++;
    if (out_bus !== '0 || out_valid !== 1'b0 || o_valid !== 1'b0 || o_full !== 1'b0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL mid_async: got %h/%b/%b/%b/%b expected all 0", out_bus, out_valid, o_valid, o_full, overflow);
    end
    #1;
    reset = 1'b1;
    wr = 8'hFF; in_bus = rep(16'h0055);
    step();
    wr = '0; rd = 1'b1;
    n_tests++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL mid_first_write: got %b expected 1", o_valid); end
    step();
    rd = 1'b0;
    n_tests++; if (out_bus !== rep(16'h0055) || out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_fresh: got %h/%b expected %h/1", out_bus, out_valid, rep(16'h0055)); end
    n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale_gone: got %b expected 0", o_valid); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_skew();
    test_full_overflow();
    test_simultaneous();
    test_empty_read();
    test_wrap();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/psum_collector.md
PSUM_COLLECTOR -- requirements
Module: psum_collector

Interface
REQ-001 Parameter col, default 8: number of array columns (lanes).
REQ-002 Parameter psum_bw, default 16: partial-sum width per lane.
REQ-003 Parameter depth, default 8, power of two >= 2: entries per lane FIFO.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port in, input, psum_bw*col: south-edge psums; lane c occupies bits [psum_bw*(c+1)-1 : psum_bw*c].
REQ-007 Port wr, input, col: per-lane write strobe, driven by the array per-column valid.
REQ-008 Port rd, input, 1: row pop request from the downstream SRAM writer.
REQ-009 Port out, output, psum_bw*col: registered popped row, with the same lane packing as in.
REQ-010 Port out_valid, output, 1: out holds a newly popped row this cycle.
REQ-011 Port o_valid, output, 1: every lane FIFO is non-empty, so a pop can be accepted.
REQ-012 Port o_full, output, 1: at least one lane FIFO is full.
REQ-013 Port overflow, output, 1: sticky flag; a write was lost.

Function
REQ-014 Each lane SHALL be an independent FIFO of depth entries, because array columns deliver psums on skewed cycles.
REQ-015 A lane write SHALL be accepted when wr[c]=1 and the lane is not full, or when it is full and a pop is accepted in the same cycle.
REQ-016 A lane write arriving while the lane is full with no same-cycle pop SHALL be dropped, SHALL leave that lane unchanged and SHALL set overflow.
REQ-017 A pop SHALL be accepted when rd=1 and o_valid=1; it removes the head entry of every lane at once.
REQ-018 rd with o_valid=0 SHALL be ignored, with no state change and no error.
REQ-019 The popped row SHALL appear on out one cycle after the accepting edge, with out_valid=1 for exactly that cycle; out SHALL hold its value otherwise.
REQ-020 A simultaneous write and pop on one lane SHALL leave that lane's occupancy unchanged.
REQ-021 A write into an empty lane SHALL be poppable no earlier than the next cycle, since o_valid is derived from registered occupancy.
REQ-022 Pointers SHALL be log2(depth) bits and wrap modulo depth; occupancy SHALL be log2(depth)+1 bits, giving full = depth and empty = 0.
REQ-023 o_valid, o_full and overflow SHALL be derived from registered state only, with no combinational path from wr or rd.
REQ-024 Data SHALL pass through bit-exact, with no sign extension or truncation.

Reset
REQ-025 Assertion of reset SHALL immediately, without waiting for a clock edge, clear all pointers and occupancies and drive out=0, out_valid=0, o_valid=0, o_full=0 and overflow=0.
REQ-026 Reset asserted mid-operation SHALL discard all stored entries; FIFO storage contents need not be cleared.
REQ-027 The first write SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-028 Shared constants COL=8, PSUM_BW=16 and DEPTH=8 SHALL live in the project-wide parameter package used by the array and core.
REQ-029 One sub-module, psum_fifo_lane (a single-lane FIFO with push, pop, full, empty and overflow), SHALL be instantiated col times in a generate loop.
REQ-030 Target implementation size is 120-400 lines of RTL in total.

Verification
REQ-031 Skewed fill: wr asserted on lane c at cycle c for c = 0..7, with lane c data = 16'h0100+c -> o_valid rises one cycle after lane 7's write edge; rd -> next cycle out = {16'h0107, ..., 16'h0100} and out_valid=1.
REQ-032 Full and overflow: 8 writes to all lanes with no rd -> o_full=1; a 9th write of 16'hDEAD -> overflow=1; 8 pops return the original 8 rows in order and never 16'hDEAD.
REQ-033 Simultaneous events: all lanes full, wr=8'hFF and rd=1 in one cycle -> overflow stays 0, o_full stays 1, the head row is popped and the new row is stored last.
REQ-034 Empty read: rd=1 for 5 cycles with nothing written -> out_valid stays 0, out stays 0, o_valid stays 0.
REQ-035 Wrap-around: 20 write/pop pairs with data = index -> out sequence 0..19 exact, with pointers wrapping at 8 and 16.
REQ-036 Mid-operation reset: 3 rows stored, reset pulsed low between clock edges -> all outputs 0 asynchronously; after release, a fresh write of 16'h0055 on all lanes pops as 16'h0055 on all lanes.
